// File: rtl/cpu_pkg.sv
// Shared encodings and constants for the instruction fetch path.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    FETCH_IMM = 2'b01,
    ISSUE     = 2'b10,
    HALT      = 2'b11
  } state_t;

  localparam int         IMM_FLAG_BIT = 7;
  localparam logic [7:0] HALT_OPCODE  = 8'hFF;
  localparam logic [7:0] RESET_PC     = 8'h00;

endpackage

// File: rtl/pc_reg.sv
// 8-bit program counter; a load (redirect) wins over an increment.
module pc_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] pc
);

  // PC update: async reset, load priority, increment wraps FF -> 00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: opcode, optional immediate, issue handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FETCH     | requesting opcode byte at PC
//   FETCH_IMM | requesting immediate byte at PC (opcode bit 7 was set)
//   ISSUE     | instr/imm presented, waiting for exec_ready
//   HALT      | HALT opcode seen, core stopped until reset
module fetch_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_data,
  input  logic       mem_valid,
  input  logic       exec_ready,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic [7:0] instr,
  output logic [7:0] imm,
  output logic       instr_valid,
  output logic [1:0] state,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] imm_q, imm_d;
  logic       pc_inc, pc_load;
  logic [7:0] pc;

  pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (branch_target),
    .pc         (pc)
  );

  // State and instruction latches; reset discards any partial instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      instr_q <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
    end
  end

  // Next-state, latch updates and PC control
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_valid) begin
          instr_d = mem_data;
          imm_d   = 8'h00;
          pc_inc  = 1'b1;
          if (mem_data == HALT_OPCODE) begin
            state_d = HALT;
          end else if (mem_data[IMM_FLAG_BIT]) begin
            state_d = FETCH_IMM;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      FETCH_IMM: begin
        if (mem_valid) begin
          imm_d   = mem_data;
          pc_inc  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_ready) begin
          pc_load = branch_taken;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign mem_req     = (state_q == FETCH) || (state_q == FETCH_IMM);
  assign instr_valid = (state_q == ISSUE);
  assign halted      = (state_q == HALT);
  assign mem_addr    = pc;
  assign instr       = instr_q;
  assign imm         = imm_q;
  assign state       = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port mem_data  input  8  byte returned by external program memory.
REQ-004 SHALL have port mem_valid  input  1  mem_data valid this cycle.
REQ-005 SHALL have port exec_ready  input  1  downstream decode/execute accepts the issued instruction.
REQ-006 SHALL have port branch_taken  input  1  PC redirect request, sampled with exec_ready.
REQ-007 SHALL have port branch_target  input  8  redirect address.
REQ-008 SHALL have port mem_req  output  1  byte fetch requested at mem_addr.
REQ-009 SHALL have port mem_addr  output  8  current PC.
REQ-010 SHALL have port instr  output  8  latched opcode, feeds control LUT.
REQ-011 SHALL have port imm  output  8  latched immediate byte.
REQ-012 SHALL have port instr_valid  output  1  instr/imm valid for issue.
REQ-013 SHALL have port state  output  2  current FSM state encoding.
REQ-014 SHALL have port halted  output  1  core stopped on HALT opcode.

Function
REQ-015 SHALL implement FSM states FETCH=2'b00, FETCH_IMM=2'b01, ISSUE=2'b10, HALT=2'b11.
REQ-016 SHALL drive mem_req=1 only in FETCH and FETCH_IMM; mem_addr=PC in all states.
REQ-017 FETCH with mem_valid=1: instr<=mem_data, imm<=8'h00, PC<=PC+1; next = HALT if mem_data=8'hFF, FETCH_IMM if mem_data[7]=1, else ISSUE.
REQ-018 FETCH_IMM with mem_valid=1: imm<=mem_data, PC<=PC+1, next ISSUE.
REQ-019 FETCH/FETCH_IMM with mem_valid=0: hold state, PC, instr, imm unchanged (unbounded wait).
REQ-020 ISSUE: instr_valid=1 (decoded from state, same cycle); instr/imm held stable until exec_ready=1.
REQ-021 ISSUE with exec_ready=1: PC<=branch_target if branch_taken=1 else unchanged; next FETCH.
REQ-022 branch_taken SHALL be ignored unless state=ISSUE and exec_ready=1 in the same cycle.
REQ-023 mem_valid SHALL be ignored when mem_req=0.
REQ-024 PC increment SHALL wrap 8'hFF -> 8'h00 without flag; immediate fetched at 8'h00 after opcode at 8'hFF.
REQ-025 HALT: mem_req=0, instr_valid=0, halted=1, PC frozen; exit only by reset.
REQ-026 Throughput with mem_valid and exec_ready held high: 2 cycles per 1-byte instruction, 3 per 2-byte.
REQ-027 All outputs except mem_req, instr_valid, halted (state-decoded) SHALL be registered.

Reset
REQ-028 rst_n low SHALL immediately force state=FETCH, PC=8'h00, instr=8'h00, imm=8'h00.
REQ-029 During reset: mem_req=1 (FETCH decode), mem_addr=8'h00, instr_valid=0, halted=0, state=2'b00.
REQ-030 Reset asserted mid-FETCH_IMM or mid-ISSUE SHALL discard the partial instruction; first fetch after release is address 8'h00.

Structure
REQ-031 Shared package cpu_pkg SHALL hold state encodings, IMM_FLAG_BIT=7, HALT_OPCODE=8'hFF, RESET_PC=8'h00.
REQ-032 PC SHALL be a sub-module pc_reg (8-bit, async reset, inc/load inputs, load priority over inc); FSM and instr/imm latches in fetch_unit.

Verification
REQ-033 Reset release, memory returns 8'h12 with mem_valid=1, exec_ready=1 -> cycle1 instr=12, state=ISSUE, instr_valid=1, imm=00; cycle2 state=FETCH, mem_addr=01.
REQ-034 Memory bytes 8'h85, 8'h3C -> instr=85, imm=3C, instr_valid in 3rd cycle, mem_addr=02 after issue.
REQ-035 ISSUE with exec_ready=0 for 4 cycles then 1 with branch_taken=1, branch_target=8'hF0 -> instr_valid held 4 cycles, next fetch at mem_addr=F0; branch_taken pulses while exec_ready=0 have no effect.
REQ-036 PC=8'hFF, bytes 8'h90, 8'h07 -> opcode fetched at FF, immediate at 00, PC=01 after.
REQ-037 Opcode 8'hFF -> state=HALT, halted=1, mem_req=0 indefinitely; rst_n pulse returns to FETCH at 8'h00.
REQ-038 rst_n asserted during FETCH_IMM with mem_valid=0 -> state=FETCH, instr=00, imm=00 asynchronously; first post-reset fetch at 8'h00.
